ttm4_exec_ctrl: RTL and testbench
=================================

TTM4_EXEC_CTRL -- requirements
Module: ttm4_exec_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 2, giving the number of cycles CPU_RST is held in state RSTC (legal values 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of CYCLE_CNT.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL change on the rising edge of CLK.
REQ-004 CLK  in  1  system clock.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 RUN_REQ  in  1  single-cycle pulse: start or resume execution.
REQ-007 STEP_REQ  in  1  single-cycle pulse: execute one instruction.
REQ-008 HALT_REQ  in  1  single-cycle pulse: stop execution.
REQ-009 ABORT  in  1  single-cycle pulse: return to IDLE from any state.
REQ-010 LD_VALID  in  1  loader word valid.
REQ-011 LD_DATA  in  15  loader instruction word {OP[4:0],SR[2:0],LR[2:0],IM[3:0]}.
REQ-012 LD_LAST  in  1  qualifies the final loader word.
REQ-013 PC  in  8  current CPU program address.
REQ-014 BRK_EN / BRK_ADDR  in  1 / 8  breakpoint enable and address.
REQ-015 LD_READY  out  1  loader handshake ready.
REQ-016 IM_WE / IM_ADDR / IM_WDATA  out  1 / 8 / 15  instruction-memory write port, all registered.
REQ-017 CPU_EN  out  1  CPU clock enable (combinational from state and inputs).
REQ-018 CPU_RST  out  1  CPU reset hold.
REQ-019 STATE  out  3  encoded state: IDLE=0, LOAD=1, RSTC=2, RUN=3, STEP=4, HALT=5.
REQ-020 HALTED / BUSY / CYCLE_CNT  out  1 / 1 / CNT_W  state==HALT; state in {LOAD,RSTC}; count of enabled CPU cycles.

Function
REQ-021 Request priority in every state SHALL be ABORT > HALT_REQ > STEP_REQ > RUN_REQ. Requests that are not legal in the current state SHALL be ignored.
REQ-022 IDLE SHALL behave as follows:
- LD_VALID=1 -> LOAD, with the load address cleared to 0.
- Otherwise RUN_REQ -> RSTC.
- CPU_RST=1; CPU_EN=0.
REQ-023 LOAD SHALL behave as follows:
- LD_READY=1.
- Each accept (LD_VALID & LD_READY) produces, on the next cycle, a 1-cycle IM_WE=1 with IM_ADDR = load address and IM_WDATA = LD_DATA; the load address then increments by 1.
- An accept with LD_LAST=1, or an accept at load address 255, -> IDLE.
- LD_READY=0 outside LOAD.
REQ-024 RSTC SHALL behave as follows:
- CPU_RST=1 for exactly RST_CYCLES cycles, then -> RUN.
- CYCLE_CNT clears to 0 on entry.
- CPU_RST=1 in IDLE, LOAD and RSTC; CPU_RST=0 in all other states.
REQ-025 RUN SHALL behave as follows:
- CPU_EN = !HALT_REQ & !ABORT & !brk_hit.
- brk_hit = BRK_EN & (PC==BRK_ADDR) & !brk_mask.
- HALT_REQ or brk_hit -> HALT in the same cycle, so the instruction at the breakpoint is not executed.
REQ-026 HALT SHALL behave as follows:
- CPU_EN=0.
- RUN_REQ -> RUN; STEP_REQ -> STEP.
- Either transition sets brk_mask=1.
REQ-027 STEP SHALL assert CPU_EN=1 for exactly one cycle, then -> HALT. Breakpoints are not evaluated in STEP.
REQ-028 brk_mask SHALL clear after the first cycle with CPU_EN=1, so that resuming from a breakpoint executes that instruction once.
REQ-029 CYCLE_CNT SHALL increment on every cycle with CPU_EN=1 and SHALL saturate at 2^CNT_W-1 (no wrap-around).
REQ-030 ABORT SHALL force IDLE on the next edge from any state; any pending IM_WE SHALL still complete, and the load address SHALL clear.
REQ-031 IM_WE SHALL never assert outside the cycle immediately following an accept.

Reset
REQ-032 While RST=1, and immediately on its assertion, the block SHALL hold:
- STATE=IDLE; CPU_RST=1.
- CPU_EN, LD_READY, IM_WE, HALTED, BUSY = 0.
- IM_ADDR, IM_WDATA, CYCLE_CNT, load address, RSTC counter, brk_mask = 0.
REQ-033 RST asserted mid-LOAD or mid-RUN SHALL discard all progress, with no further IM_WE pulse.

Verification
REQ-034 Load 3 words 0x1234, 0x0ABC, 0x7FFF with LD_LAST on the third -> IM_WE pulses at addresses 0, 1, 2 with matching data; STATE returns to 0.
REQ-035 Load 256 words without LD_LAST -> last write at IM_ADDR=255, then IDLE; LD_READY=0 afterwards.
REQ-036 RUN_REQ from IDLE -> CPU_RST high for 2 cycles, then CPU_EN=1; CYCLE_CNT=10 after 10 RUN cycles.
REQ-037 BRK_EN=1, BRK_ADDR=0x05, PC reaches 0x05 -> CPU_EN=0 in that cycle and HALTED=1; a subsequent RUN_REQ executes PC 0x05 once, with no re-halt.
REQ-038 In HALT, STEP_REQ -> exactly one CPU_EN cycle, then HALTED=1; STEP_REQ and RUN_REQ in the same cycle -> STEP wins.
REQ-039 Preload CYCLE_CNT to 0xFFFE with CNT_W=16 -> after 3 RUN cycles it reads 0xFFFF; ABORT in RUN -> STATE=0 and CPU_RST=1 on the next cycle.

Source files
------------

// File: rtl/ttm4_exec_ctrl.sv
// ttm4_exec_ctrl -- execution controller for a small CPU core.
//
// Loads a program into instruction memory, holds the CPU in reset for a
// fixed number of cycles, then runs it. While running it can halt on
// request or on a PC breakpoint and single-step from the halted state.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   runReq           pulse: start (from IDLE) or resume (from HALT)
//   stepReq          pulse: execute one instruction (from HALT)
//   haltReq          pulse: stop execution
//   abort            pulse: return to IDLE from any state
//   ldValid/ldData/ldLast/ldReady  loader word stream (valid/ready)
//   pc               current CPU program address
//   brkEn/brkAddr    breakpoint enable and address
//   imWe/imAddr/imWdata  registered instruction-memory write port
//   cpuEn            CPU clock enable (combinational)
//   cpuRst           CPU reset hold
//   state            IDLE=0 LOAD=1 RSTC=2 RUN=3 STEP=4 HALT=5
//   halted/busy      state==HALT / state in {LOAD,RSTC}
//   cycleCnt         saturating count of enabled CPU cycles
module ttm4_exec_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             runReq,
  input  logic             stepReq,
  input  logic             haltReq,
  input  logic             abort,
  input  logic             ldValid,
  input  logic [14:0]      ldData,
  input  logic             ldLast,
  input  logic [7:0]       pc,
  input  logic             brkEn,
  input  logic [7:0]       brkAddr,
  output logic             ldReady,
  output logic             imWe,
  output logic [7:0]       imAddr,
  output logic [14:0]      imWdata,
  output logic             cpuEn,
  output logic             cpuRst,
  output logic [2:0]       state,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] cycleCnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RSTC = 3'd2,
    RUN  = 3'd3,
    STEP = 3'd4,
    HALT = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       RST_LAST = 4'(RST_CYCLES - 1);

  state_t     st;
  logic [7:0] ldAddr;
  logic [3:0] rstCnt;
  logic       brkMask;
  logic       accept;
  logic       brkHit;

  assign ldReady = (st == LOAD);
  assign accept  = ldValid & ldReady;
  // brkMask suppresses the breakpoint for the instruction we just halted on,
  // so a resume executes it once instead of re-halting immediately.
  assign brkHit  = brkEn & (pc == brkAddr) & ~brkMask;

  assign cpuRst  = (st == IDLE) | (st == LOAD) | (st == RSTC);
  assign halted  = (st == HALT);
  assign busy    = (st == LOAD) | (st == RSTC);
  assign state   = st;

  // In RUN the enable drops in the same cycle as a halt/abort/breakpoint so
  // the instruction at that PC is not executed.
  always_comb begin
    cpuEn = 1'b0;
    case (st)
      RUN:     cpuEn = ~haltReq & ~abort & ~brkHit;
      STEP:    cpuEn = 1'b1;
      default: cpuEn = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      ldAddr   <= '0;
      rstCnt   <= '0;
      brkMask  <= 1'b0;
      cycleCnt <= '0;
      imWe     <= 1'b0;
      imAddr   <= '0;
      imWdata  <= '0;
    end else begin
      // Write port: one-cycle pulse after every accept, even if abort
      // arrives in the same cycle.
      imWe <= accept;
      if (accept) begin
        imAddr  <= ldAddr;
        imWdata <= ldData;
        ldAddr  <= ldAddr + 8'd1;
      end

      if (cpuEn && (cycleCnt != CNT_MAX))
        cycleCnt <= cycleCnt + CNT_W'(1);
      if (cpuEn)
        brkMask <= 1'b0;

      if (abort) begin
        st      <= IDLE;
        ldAddr  <= '0;
        brkMask <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (ldValid) begin
              st     <= LOAD;
              ldAddr <= '0;
            end else if (runReq) begin
              st       <= RSTC;
              rstCnt   <= '0;
              cycleCnt <= '0;
            end
          end
          LOAD: begin
            // Address 255 is the last slot; stop there even without ldLast.
            if (accept && (ldLast || (ldAddr == 8'hFF)))
              st <= IDLE;
          end
          RSTC: begin
            if (rstCnt == RST_LAST)
              st <= RUN;
            else
              rstCnt <= rstCnt + 4'd1;
          end
          RUN: begin
            if (haltReq || brkHit)
              st <= HALT;
          end
          STEP: st <= HALT;
          HALT: begin
            // haltReq outranks step/run and simply keeps us halted.
            if (!haltReq && (stepReq || runReq)) begin
              st      <= stepReq ? STEP : RUN;
              brkMask <= 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttm4_exec_ctrl.sv
// Bench for ttm4_exec_ctrl: instruction-memory writes are checked against a
// queue of expected {addr,data} pushed when each loader word is offered;
// control behaviour is checked inline in one task per scenario.
module tb_ttm4_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        runReq, stepReq, haltReq, abort;
  logic        ldValid, ldLast;
  logic [14:0] ldData;
  logic [7:0]  pc, brkAddr;
  logic        brkEn;
  logic        ldReady, imWe, cpuEn, cpuRst, halted, busy;
  logic [7:0]  imAddr;
  logic [14:0] imWdata;
  logic [2:0]  state;
  logic [15:0] cycleCnt;

  int nCmp = 0;
  int nErr = 0;
  int expCnt = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [14:0] d;
  } wr_t;
  wr_t sbQ[$];

  ttm4_exec_ctrl #(.RST_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .runReq(runReq), .stepReq(stepReq),
    .haltReq(haltReq), .abort(abort), .ldValid(ldValid), .ldData(ldData),
    .ldLast(ldLast), .pc(pc), .brkEn(brkEn), .brkAddr(brkAddr),
    .ldReady(ldReady), .imWe(imWe), .imAddr(imAddr), .imWdata(imWdata),
    .cpuEn(cpuEn), .cpuRst(cpuRst), .state(state), .halted(halted),
    .busy(busy), .cycleCnt(cycleCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every write pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (imWe) begin
      wr_t e;
      nCmp++;
      if (sbQ.size() == 0) begin
        nErr++;
        $display("FAIL im_we_unexpected got addr=%h data=%h want no write", imAddr, imWdata);
      end else begin
        e = sbQ.pop_front();
        if (imAddr !== e.a || imWdata !== e.d) begin
          nErr++;
          $display("FAIL im_write got addr=%h data=%h want addr=%h data=%h", imAddr, imWdata, e.a, e.d);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; runReq = 0; stepReq = 0; haltReq = 0; abort = 0;
    ldValid = 0; ldLast = 0; ldData = '0; pc = '0; brkEn = 0; brkAddr = '0;
    #1;
    nCmp++; if (state !== 3'd0 || cpuRst !== 1'b1) begin nErr++; $display("FAIL reset_async state=%0d cpuRst=%b want 0/1", state, cpuRst); end
    @(negedge clk); @(negedge clk);
    nCmp++; if (state !== 3'd0 || cpuRst !== 1'b1) begin nErr++; $display("FAIL reset_state state=%0d cpuRst=%b want 0/1", state, cpuRst); end
    nCmp++; if ({cpuEn, ldReady, imWe, halted, busy} !== 5'b0) begin nErr++; $display("FAIL reset_flags got %b want 00000", {cpuEn, ldReady, imWe, halted, busy}); end
    nCmp++; if (imAddr !== 8'h0 || imWdata !== 15'h0 || cycleCnt !== 16'h0) begin nErr++; $display("FAIL reset_regs addr=%h data=%h cnt=%h want 0", imAddr, imWdata, cycleCnt); end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_load3();
    logic [14:0] words [3];
    words[0] = 15'h1234; words[1] = 15'h0ABC; words[2] = 15'h7FFF;
    ldValid = 1; ldData = words[0];
    cyc();
    @(negedge clk);
    nCmp++; if (state !== 3'd1 || ldReady !== 1'b1 || busy !== 1'b1) begin nErr++; $display("FAIL load3_enter state=%0d rdy=%b busy=%b want 1/1/1", state, ldReady, busy); end
    for (int i = 0; i < 3; i++) begin
      ldData = words[i]; ldLast = (i == 2);
      sbQ.push_back({8'(i), words[i]});
      cyc();
    end
    ldValid = 0; ldLast = 0;
    @(negedge clk);
    nCmp++; if (state !== 3'd0 || ldReady !== 1'b0) begin nErr++; $display("FAIL load3_exit state=%0d rdy=%b want 0/0", state, ldReady); end
    cyc(); cyc();
  endtask

  task automatic test_load256();
    ldValid = 1; ldLast = 0; ldData = 15'h0;
    cyc();
    for (int i = 0; i < 256; i++) begin
      ldData = 15'((i * 37 + 5) & 16'h7FFF);
      sbQ.push_back({8'(i), ldData});
      cyc();
    end
    ldValid = 0;
    @(negedge clk);
    nCmp++; if (state !== 3'd0 || ldReady !== 1'b0) begin nErr++; $display("FAIL load256_exit state=%0d rdy=%b want 0/0", state, ldReady); end
    cyc();
    @(negedge clk);
    nCmp++; if (ldReady !== 1'b0 || imWe !== 1'b0) begin nErr++; $display("FAIL load256_after rdy=%b we=%b want 0/0", ldReady, imWe); end
    cyc();
  endtask

  task automatic test_rst_midload();
    ldValid = 1; ldData = 15'h5555;
    cyc();                 // IDLE -> LOAD
    cyc();                 // word accepted, write pulse would follow
    rst = 1'b1; ldValid = 0;
    @(negedge clk);
    nCmp++; if (imWe !== 1'b0 || state !== 3'd0 || ldReady !== 1'b0) begin nErr++; $display("FAIL rst_midload we=%b state=%0d rdy=%b want 0/0/0", imWe, state, ldReady); end
    cyc();
    rst = 1'b0;
    cyc();
    ldValid = 1; ldLast = 1; ldData = 15'h2AAA;
    cyc();
    sbQ.push_back({8'h00, 15'h2AAA});
    cyc();
    ldValid = 0; ldLast = 0;
    cyc(); cyc();
  endtask

  task automatic test_run();
    runReq = 1;
    cyc();
    runReq = 0;
    @(negedge clk);
    nCmp++; if (state !== 3'd2 || cpuRst !== 1'b1 || cpuEn !== 1'b0 || busy !== 1'b1) begin nErr++; $display("FAIL rstc_1 state=%0d rst=%b en=%b busy=%b want 2/1/0/1", state, cpuRst, cpuEn, busy); end
    cyc();
    @(negedge clk);
    nCmp++; if (state !== 3'd2 || cpuRst !== 1'b1) begin nErr++; $display("FAIL rstc_2 state=%0d rst=%b want 2/1", state, cpuRst); end
    cyc();
    @(negedge clk);
    nCmp++; if (state !== 3'd3 || cpuRst !== 1'b0 || cpuEn !== 1'b1 || cycleCnt !== 16'd0) begin nErr++; $display("FAIL run_enter state=%0d rst=%b en=%b cnt=%0d want 3/0/1/0", state, cpuRst, cpuEn, cycleCnt); end
    repeat (10) cyc();
    expCnt = 10;
    @(negedge clk);
    nCmp++; if (cycleCnt !== 16'(expCnt)) begin nErr++; $display("FAIL run_count got %0d want %0d", cycleCnt, expCnt); end
    haltReq = 1;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b0) begin nErr++; $display("FAIL halt_req_en got %b want 0", cpuEn); end
    cyc();
    haltReq = 0;
    @(negedge clk);
    nCmp++; if (state !== 3'd5 || halted !== 1'b1 || cpuEn !== 1'b0) begin nErr++; $display("FAIL halt_state state=%0d halted=%b en=%b want 5/1/0", state, halted, cpuEn); end
  endtask

  task automatic test_break();
    brkEn = 1; brkAddr = 8'h05; pc = 8'h00; runReq = 1;
    cyc();
    runReq = 0;
    for (int p = 0; p < 5; p++) begin
      pc = 8'(p);
      @(negedge clk);
      nCmp++; if (cpuEn !== 1'b1) begin nErr++; $display("FAIL brk_pre pc=%0d en=%b want 1", p, cpuEn); end
      expCnt++;
      cyc();
    end
    pc = 8'h05;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b0 || state !== 3'd3) begin nErr++; $display("FAIL brk_hit en=%b state=%0d want 0/3", cpuEn, state); end
    cyc();
    @(negedge clk);
    nCmp++; if (halted !== 1'b1 || state !== 3'd5) begin nErr++; $display("FAIL brk_halt halted=%b state=%0d want 1/5", halted, state); end
    runReq = 1;
    cyc();
    runReq = 0;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b1 || state !== 3'd3) begin nErr++; $display("FAIL brk_resume en=%b state=%0d want 1/3", cpuEn, state); end
    expCnt++;
    cyc();
    pc = 8'h06;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b1 || state !== 3'd3) begin nErr++; $display("FAIL brk_noreh en=%b state=%0d want 1/3", cpuEn, state); end
    expCnt++;
    cyc();
    pc = 8'h05;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b0) begin nErr++; $display("FAIL brk_rearm en=%b want 0", cpuEn); end
    cyc();
    @(negedge clk);
    nCmp++; if (state !== 3'd5 || cycleCnt !== 16'(expCnt)) begin nErr++; $display("FAIL brk_end state=%0d cnt=%0d want 5/%0d", state, cycleCnt, expCnt); end
  endtask

  task automatic test_step();
    stepReq = 1;
    cyc();
    stepReq = 0;
    @(negedge clk);
    nCmp++; if (state !== 3'd4 || cpuEn !== 1'b1) begin nErr++; $display("FAIL step_on state=%0d en=%b want 4/1", state, cpuEn); end
    expCnt++;
    cyc();
    @(negedge clk);
    nCmp++; if (state !== 3'd5 || halted !== 1'b1 || cpuEn !== 1'b0) begin nErr++; $display("FAIL step_off state=%0d halted=%b en=%b want 5/1/0", state, halted, cpuEn); end
    stepReq = 1; runReq = 1;
    cyc();
    stepReq = 0; runReq = 0;
    @(negedge clk);
    nCmp++; if (state !== 3'd4 || cpuEn !== 1'b1) begin nErr++; $display("FAIL step_wins state=%0d en=%b want 4/1", state, cpuEn); end
    expCnt++;
    cyc();
    @(negedge clk);
    nCmp++; if (state !== 3'd5 || cycleCnt !== 16'(expCnt)) begin nErr++; $display("FAIL step_end state=%0d cnt=%0d want 5/%0d", state, cycleCnt, expCnt); end
  endtask

  task automatic test_saturate_abort();
    abort = 1;
    cyc();
    abort = 0;
    @(negedge clk);
    nCmp++; if (state !== 3'd0 || cpuRst !== 1'b1) begin nErr++; $display("FAIL abort_halt state=%0d rst=%b want 0/1", state, cpuRst); end
    brkEn = 0; runReq = 1;
    cyc();
    runReq = 0;
    cyc(); cyc();          // two RSTC cycles, now in RUN with count 0
    repeat (65534) cyc();
    @(negedge clk);
    nCmp++; if (cycleCnt !== 16'hFFFE) begin nErr++; $display("FAIL cnt_preload got %h want fffe", cycleCnt); end
    repeat (3) cyc();
    @(negedge clk);
    nCmp++; if (cycleCnt !== 16'hFFFF) begin nErr++; $display("FAIL cnt_saturate got %h want ffff", cycleCnt); end
    abort = 1;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b0) begin nErr++; $display("FAIL abort_en got %b want 0", cpuEn); end
    cyc();
    abort = 0;
    @(negedge clk);
    nCmp++; if (state !== 3'd0 || cpuRst !== 1'b1 || cpuEn !== 1'b0) begin nErr++; $display("FAIL abort_run state=%0d rst=%b en=%b want 0/1/0", state, cpuRst, cpuEn); end
  endtask

  initial begin
    test_reset();
    test_load3();
    test_load256();
    test_rst_midload();
    test_run();
    test_break();
    test_step();
    test_saturate_abort();
    cyc(); cyc();
    nCmp++; if (sbQ.size() != 0) begin nErr++; $display("FAIL sb_drain got %0d pending writes want 0", sbQ.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
